// File: rtl/rs_bist_pkg.sv
// rs_bist_pkg: shared constants, driver state encoding and status counter type for the RS decoder BIST harness.
package rs_bist_pkg;
  localparam int RS_N = 204;
  localparam int RS_K = 188;
  localparam int MIN_GAP = 6;
  typedef enum logic [2:0] {IDLE, FETCH, STROBE, LOW, GAP, DRAIN, DONE} state_t;
  typedef logic [15:0] stat_t;
endpackage

// File: rtl/rs_bist_harness_if.sv
// rs_bist_harness_if: stimulus/expected ROM ports and decoder CE handshake between the harness and its surroundings.
interface rs_bist_harness_if #(
  parameter int SYM_W = 8,
  parameter int SA_W = 9,
  parameter int EA_W = 9
);
  logic [SA_W-1:0] stim_addr;
  logic [SYM_W-1:0] stim_data;
  logic [EA_W-1:0] exp_addr;
  logic [SYM_W-1:0] exp_data;
  logic dut_ce;
  logic [SYM_W-1:0] dut_byte;
  logic [SYM_W-1:0] dut_out;
  logic dut_ceo;
  logic dut_valid;
  modport master(output stim_addr, exp_addr, dut_ce, dut_byte,
                 input stim_data, exp_data, dut_out, dut_ceo, dut_valid);
  modport slave(input stim_addr, exp_addr, dut_ce, dut_byte,
                output stim_data, exp_data, dut_out, dut_ceo, dut_valid);
endinterface

// File: rtl/rs_bist_checker.sv
// rs_bist_checker: compares qualified decoder outputs against a prefetched expected ROM and keeps the status counters.
module rs_bist_checker import rs_bist_pkg::*; #(
  parameter int SYM_W = 8,
  parameter int TOT = 376,
  parameter int EA_W = 9
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic dut_valid,
  input  logic dut_ceo,
  input  logic [SYM_W-1:0] dut_out,
  input  logic [SYM_W-1:0] exp_data,
  output logic [EA_W-1:0] exp_addr,
  output logic hit,
  output logic cmp_done,
  output stat_t err_count,
  output stat_t out_count,
  output stat_t first_err
);
  localparam int H_W = $clog2(TOT + 1);
  logic [H_W-1:0] h_q, h_d;
  logic [SYM_W-1:0] exp_q;
  stat_t err_q, err_d, out_q, out_d, first_q, first_d;
  logic miss;
  // exp_q trails exp_addr by two cycles; CEO spacing keeps it settled before the next compare
  always_comb begin
    cmp_done = h_q == H_W'(TOT);
    hit = en && dut_valid && dut_ceo && !cmp_done;
    miss = hit && dut_out != exp_q;
    h_d = clr ? '0 : h_q + H_W'(hit);
    out_d = clr ? '0 : out_q + stat_t'(hit);
    err_d = clr ? '0 : err_q + stat_t'(miss && err_q != '1);
    first_d = clr ? '1 : (miss && first_q == '1) ? stat_t'(h_q) : first_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      h_q <= '0;
      exp_q <= '0;
      err_q <= '0;
      out_q <= '0;
      first_q <= '1;
    end else begin
      h_q <= h_d;
      exp_q <= exp_data;
      err_q <= err_d;
      out_q <= out_d;
      first_q <= first_d;
    end
  assign exp_addr = EA_W'(h_q);
  assign err_count = err_q;
  assign out_count = out_q;
  assign first_err = first_q;
endmodule

// File: rtl/rs_bist_harness.sv
// rs_bist_harness: drives ROM codewords into an RS decoder with a paced CE handshake and reports the checker verdict.
module rs_bist_harness import rs_bist_pkg::*; #(
  parameter int SYM_W = 8,
  parameter int N = RS_N,
  parameter int K = RS_K,
  parameter int NUM_CW = 2,
  parameter int GAP_W = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [GAP_W-1:0] gap_cfg,
  rs_bist_harness_if.master bus,
  output logic busy,
  output logic done,
  output logic pass,
  output logic timeout,
  output stat_t err_count,
  output stat_t out_count,
  output stat_t first_err
);
  localparam int TOT_IN = NUM_CW * N;
  localparam int SA_W = $clog2(TOT_IN);
  localparam int EA_W = $clog2(NUM_CW * K);
  localparam int K_W = $clog2(TOT_IN + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  state_t state_q, state_d;
  logic [K_W-1:0] k_q, k_d;
  logic [GAP_W-1:0] geff_q, geff_d, gcnt_q, gcnt_d;
  logic [SYM_W-1:0] byte_q, byte_d;
  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic done_q, done_d, pass_q, pass_d, to_q, to_d;
  logic go, hit, cmp_done, expired;
  rs_bist_checker #(.SYM_W(SYM_W), .TOT(NUM_CW * K), .EA_W(EA_W)) u_chk (
    .clk(clk), .reset(reset), .clr(go), .en(busy),
    .dut_valid(bus.dut_valid), .dut_ceo(bus.dut_ceo), .dut_out(bus.dut_out),
    .exp_data(bus.exp_data), .exp_addr(bus.exp_addr), .hit(hit), .cmp_done(cmp_done),
    .err_count(err_count), .out_count(out_count), .first_err(first_err)
  );
  // k advances on the strobe so the next stimulus word is already on stim_data by the following FETCH
  always_comb begin
    go = state_q == IDLE && start;
    expired = tcnt_q == TO_W'(TIMEOUT) && state_q != IDLE && state_q != DONE;
    tcnt_d = (go || state_q == STROBE || hit) ? '0 : busy ? tcnt_q + TO_W'(1) : tcnt_q;
    state_d = state_q;
    k_d = k_q;
    geff_d = geff_q;
    gcnt_d = gcnt_q;
    byte_d = byte_q;
    done_d = done_q;
    pass_d = pass_q;
    to_d = to_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        geff_d = gap_cfg < GAP_W'(MIN_GAP) ? GAP_W'(MIN_GAP) : gap_cfg;
        done_d = 1'b0;
        pass_d = 1'b0;
        to_d = 1'b0;
      end
      FETCH: begin
        byte_d = bus.stim_data;
        state_d = STROBE;
      end
      STROBE: begin
        k_d = k_q + K_W'(1);
        state_d = LOW;
      end
      LOW: begin
        gcnt_d = '0;
        state_d = GAP;
      end
      GAP: begin
        gcnt_d = gcnt_q + GAP_W'(1);
        if (gcnt_q == geff_q - GAP_W'(1)) state_d = k_q == K_W'(TOT_IN) ? DRAIN : FETCH;
      end
      DRAIN: if (cmp_done) state_d = DONE;
      DONE: begin
        k_d = '0;
        done_d = 1'b1;
        pass_d = err_count == '0 && !to_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (expired) begin
      to_d = 1'b1;
      state_d = DONE;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      k_q <= '0;
      geff_q <= '0;
      gcnt_q <= '0;
      byte_q <= '0;
      tcnt_q <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      geff_q <= geff_d;
      gcnt_q <= gcnt_d;
      byte_q <= byte_d;
      tcnt_q <= tcnt_d;
      done_q <= done_d;
      pass_q <= pass_d;
      to_q <= to_d;
    end
  assign bus.stim_addr = SA_W'(k_q);
  assign bus.dut_ce = state_q == STROBE;
  assign bus.dut_byte = byte_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign pass = pass_q;
  assign timeout = to_q;
endmodule
